// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and defaults
package mips_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_WORD             = 32'h0000_0000;
   localparam int          DEFAULT_PC_STEP      = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/response bus
interface instr_fetch_unit_if #(
   parameter int BUS_SIZE = 32,
   parameter int DIR_SIZE = 32
);
   logic                imem_req;
   logic [DIR_SIZE-1:0] imem_addr;
   logic                imem_ready;
   logic [BUS_SIZE-1:0] imem_data;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with sequential/redirect next-value select
module pc_reg
   import mips_pkg::*;
#(
   parameter int                  DIR_SIZE     = 32,
   parameter logic [DIR_SIZE-1:0] RESET_VECTOR = DIR_SIZE'(DEFAULT_RESET_VECTOR),
   parameter int                  PC_STEP      = DEFAULT_PC_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                sel,
   input  logic [DIR_SIZE-1:0] target,
   output logic [DIR_SIZE-1:0] pc,
   output logic                misaligned
);

   logic [DIR_SIZE-1:0] next_pc;
   logic                next_mis;

   // Redirect targets are forced word-aligned; the dropped low bits are reported instead.
   always_comb begin
      next_pc  = pc + DIR_SIZE'(PC_STEP);
      next_mis = 1'b0;
      if (sel) begin
         next_pc  = {target[DIR_SIZE-1:2], 2'b00};
         next_mis = |target[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= RESET_VECTOR;
         misaligned <= 1'b0;
      end else if (load) begin
         pc         <= next_pc;
         misaligned <= next_mis;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle fetch stage, one instruction in flight
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int                  BUS_SIZE     = 32,
   parameter int                  DIR_SIZE     = 32,
   parameter logic [DIR_SIZE-1:0] RESET_VECTOR = DIR_SIZE'(DEFAULT_RESET_VECTOR),
   parameter int                  PC_STEP      = DEFAULT_PC_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enPC,
   input  logic                muxPC,
   input  logic [DIR_SIZE-1:0] dirPC,
   instr_fetch_unit_if.master  imem,
   output logic [BUS_SIZE-1:0] opCode,
   output logic                opValid,
   output logic [DIR_SIZE-1:0] pcCurrent,
   output logic                pcMisaligned
);

   fetch_state_t        state;
   logic                req_q;
   logic [DIR_SIZE-1:0] pc;
   logic                pc_load;

   // PC only moves from S_HOLD, so a redirect can never disturb an outstanding fetch.
   assign pc_load = (state == S_HOLD) && enPC;

   pc_reg #(
      .DIR_SIZE     (DIR_SIZE),
      .RESET_VECTOR (RESET_VECTOR),
      .PC_STEP      (PC_STEP)
   ) u_pc_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (pc_load),
      .sel        (muxPC),
      .target     (dirPC),
      .pc         (pc),
      .misaligned (pcMisaligned)
   );

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_BOOT;
         req_q     <= 1'b0;
         opCode    <= BUS_SIZE'(NOP_WORD);
         opValid   <= 1'b0;
         pcCurrent <= RESET_VECTOR;
      end else begin
         case (state)
            S_BOOT: begin
               state <= S_FETCH;
               req_q <= 1'b1;
            end
            S_FETCH: begin
               if (imem.imem_ready) begin
                  opCode    <= imem.imem_data;
                  pcCurrent <= pc;
                  opValid   <= 1'b1;
                  req_q     <= 1'b0;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (enPC) begin
                  opValid <= 1'b0;
                  req_q   <= 1'b1;
                  state   <= S_FETCH;
               end
            end
            default: begin
               state <= S_BOOT;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        enPC;
   logic        muxPC;
   logic [31:0] dirPC;
   logic [31:0] opCode;
   logic        opValid;
   logic [31:0] pcCurrent;
   logic        pcMisaligned;

   int   checks;
   int   failures;
   exp_t exp_q[$];

   instr_fetch_unit_if #(.BUS_SIZE(32), .DIR_SIZE(32)) imem ();

   instr_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .enPC         (enPC),
      .muxPC        (muxPC),
      .dirPC        (dirPC),
      .imem         (imem.master),
      .opCode       (opCode),
      .opValid      (opValid),
      .pcCurrent    (pcCurrent),
      .pcMisaligned (pcMisaligned)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && opValid !== 1'b1; i++) step();
      check("op_valid_wait", {31'd0, opValid}, 32'd1);
   endtask

   task automatic do_fetch(input logic mux, input logic [31:0] dir, input logic [31:0] data,
                           input logic [31:0] eaddr, input logic emis);
      exp_q.push_back('{eaddr, data, emis});
      imem.imem_data = data;
      muxPC = mux;
      dirPC = dir;
      enPC  = 1'b1;
      step();
      enPC  = 1'b0;
      check("op_valid_drop", {31'd0, opValid}, 32'd0);
      wait_valid();
   endtask

   // Monitor: every accepted handshake consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (imem.imem_req === 1'b1 && imem.imem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_fetch actual=%h expected=none", imem.imem_addr);
            end else begin
               e = exp_q.pop_front();
               check("fetch_addr", imem.imem_addr, e.addr);
               check("pc_misaligned", {31'd0, pcMisaligned}, {31'd0, e.mis});
               @(negedge clk);
               check("op_code", opCode, e.data);
               check("op_valid", {31'd0, opValid}, 32'd1);
               check("pc_current", pcCurrent, e.addr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      enPC     = 1'b0;
      muxPC    = 1'b0;
      dirPC    = 32'd0;
      imem.imem_ready = 1'b1;
      imem.imem_data  = 32'hAD40_0000;
      #1;
      check("rst_req", {31'd0, imem.imem_req}, 32'd0);
      check("rst_op_valid", {31'd0, opValid}, 32'd0);
      check("rst_op_code", opCode, 32'd0);
      check("rst_pc_current", pcCurrent, 32'd0);
      check("rst_misaligned", {31'd0, pcMisaligned}, 32'd0);

      // Boot fetch
      exp_q.push_back('{32'h0, 32'hAD40_0000, 1'b0});
      step();
      step();
      rst = 1'b1;
      step();
      check("boot_req", {31'd0, imem.imem_req}, 32'd1);
      check("boot_addr", imem.imem_addr, 32'h0);
      wait_valid();
      step();

      // Sequential advance
      do_fetch(1'b0, 32'h0, 32'h1111_1111, 32'h4, 1'b0);
      do_fetch(1'b0, 32'h0, 32'h2222_2222, 32'h8, 1'b0);
      do_fetch(1'b0, 32'h0, 32'h3333_3333, 32'hC, 1'b0);

      // Wait states
      exp_q.push_back('{32'h10, 32'h4444_4444, 1'b0});
      imem.imem_ready = 1'b0;
      imem.imem_data  = 32'hDEAD_BEEF;
      muxPC = 1'b0;
      enPC  = 1'b1;
      step();
      enPC  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_req", {31'd0, imem.imem_req}, 32'd1);
         check("stall_addr", imem.imem_addr, 32'h10);
         check("stall_op_valid", {31'd0, opValid}, 32'd0);
         step();
      end
      imem.imem_data  = 32'h4444_4444;
      imem.imem_ready = 1'b1;
      wait_valid();

      // Misaligned redirect then sequential
      do_fetch(1'b1, 32'h0000_1003, 32'h5555_5555, 32'h1000, 1'b1);
      check("mis_sticky", {31'd0, pcMisaligned}, 32'd1);
      do_fetch(1'b0, 32'h0, 32'h6666_6666, 32'h1004, 1'b0);

      // Wraparound
      do_fetch(1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 32'hFFFF_FFFC, 1'b0);
      do_fetch(1'b0, 32'h0, 32'h8888_8888, 32'h0, 1'b0);

      // enPC during fetch, then reset mid-fetch
      imem.imem_ready = 1'b0;
      muxPC = 1'b0;
      enPC  = 1'b1;
      step();
      muxPC = 1'b1;
      dirPC = 32'h0000_2000;
      step();
      step();
      enPC  = 1'b0;
      check("enpc_in_fetch_addr", imem.imem_addr, 32'h4);
      check("enpc_in_fetch_req", {31'd0, imem.imem_req}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_req", {31'd0, imem.imem_req}, 32'd0);
      check("async_rst_op_valid", {31'd0, opValid}, 32'd0);
      check("async_rst_addr", imem.imem_addr, 32'h0);
      exp_q.push_back('{32'h0, 32'h9999_9999, 1'b0});
      imem.imem_data  = 32'h9999_9999;
      imem.imem_ready = 1'b1;
      step();
      rst = 1'b1;
      step();
      check("restart_req", {31'd0, imem.imem_req}, 32'd1);
      check("restart_addr", imem.imem_addr, 32'h0);
      wait_valid();
      step();
      step();
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
